// File: rtl/fetch_unit_pkg.sv
// Shared opcode, field and state definitions for the fetch stage and the decoder.
package fetch_unit_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LDM  = 5'b00111;
  localparam opcode_t OP_LDD  = 5'b01110;
  localparam opcode_t OP_STD  = 5'b01111;
  localparam opcode_t OP_SHL  = 5'b10100;
  localparam opcode_t OP_SHR  = 5'b10101;
  localparam opcode_t OP_JMP  = 5'b11000;
  localparam opcode_t OP_CALL = 5'b11001;
  localparam opcode_t OP_RET  = 5'b11010;
  localparam opcode_t OP_RTI  = 5'b11011;
  localparam opcode_t OP_NOP  = 5'b11111;

  typedef enum logic [1:0] {
    StFetchOp  = 2'd0,
    StFetchImm = 2'd1,
    StIssue    = 2'd2,
    StDrain    = 2'd3
  } fetch_state_e;

  function automatic opcode_t get_opcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Instruction length decode: flags opcodes that carry a second (immediate) word.
module fetch_len_decode
  import fetch_unit_pkg::*;
(
  input  opcode_t opcode_i,
  output logic    needs_imm_o
);

  always_comb begin
    needs_imm_o = 1'b0;
    case (opcode_i)
      OP_LDM, OP_LDD, OP_STD, OP_SHL, OP_SHR: needs_imm_o = 1'b1;
      default:                                needs_imm_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: fetches one- or two-word instructions from a
// variable-latency memory and hands them to decode over a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [15:0]       inst,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [15:0]       inst_q, inst_d;
  logic [15:0]       imm_q, imm_d;
  logic              imem_req_q, imem_req_d;
  opcode_t           rsp_opcode;
  logic              needs_imm;
  logic              rsp;

  assign rsp_opcode = get_opcode(imem_rdata);

  fetch_len_decode u_len_decode (
    .opcode_i    (rsp_opcode),
    .needs_imm_o (needs_imm)
  );

  // A response only counts while our own request is still outstanding.
  assign rsp = imem_req_q & imem_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imm_d      = imm_q;
    inst_pc_d  = inst_pc_q;
    imem_req_d = 1'b0;

    unique case (state_q)
      StFetchOp, StFetchImm: begin
        if (pc_load) begin
          pc_d    = pc_load_addr;
          // Without a request in flight there is nothing to drain.
          state_d = (imem_req_q && !imem_valid) ? StDrain : StFetchOp;
        end else if (rsp) begin
          pc_d = pc_q + ADDR_W'(1);
          if (state_q == StFetchOp) begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            imm_d     = '0;
            state_d   = needs_imm ? StFetchImm : StIssue;
          end else begin
            imm_d   = imem_rdata;
            state_d = StIssue;
          end
        end else begin
          imem_req_d = 1'b1;
        end
      end
      StIssue: begin
        if (pc_load) begin
          pc_d    = pc_load_addr;
          state_d = StFetchOp;
        end else if (inst_ready) begin
          state_d = StFetchOp;
        end
      end
      StDrain: begin
        if (pc_load) begin
          pc_d = pc_load_addr;
        end
        if (imem_valid) begin
          state_d = StFetchOp;
        end
      end
      default: state_d = StFetchOp;
    endcase

    // pc_d only moves when the request drops, so the address is stable while req is high.
    imem_addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetchOp;
      pc_q        <= RESET_VECTOR;
      imem_addr_q <= RESET_VECTOR;
      imem_req_q  <= 1'b0;
      inst_q      <= '0;
      imm_q       <= '0;
      inst_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      inst_q      <= inst_d;
      imm_q       <= imm_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (state_q == StIssue);
  assign inst       = inst_q;
  assign imm        = imm_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model, request and
// issue monitors fed from expected-value queues, plus a 4-bit-address instance for wrap.
module tb_fetch_unit;

  localparam int unsigned AW = 16;

  localparam int unsigned WValid   = 0;
  localparam int unsigned WReq     = 1;
  localparam int unsigned WRsp     = 2;
  localparam int unsigned WValidPc = 3;
  localparam int unsigned WHs      = 4;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] imm;
    logic [15:0] pc;
  } issue_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [15:0]   imem_rdata = '0;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst;
  logic [15:0]   imm;
  logic [AW-1:0] inst_pc;

  logic          rst4_n;
  logic          req4;
  logic [3:0]    addr4;
  logic          valid4;
  logic [15:0]   rdata4;
  logic          pc_load4;
  logic [3:0]    pc_load_addr4;
  logic          inst_valid4;
  logic          ready4;
  logic [15:0]   inst4;
  logic [15:0]   imm4;
  logic [3:0]    inst_pc4;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_hs = 0;
  issue_t      exp_inst[$];
  logic [15:0] exp_req[$];
  int          hs_cyc[$];
  logic [3:0]  req4_log[$];
  issue_t      got_e;
  logic [15:0] got_a;

  logic [15:0] mem [0:255];
  logic [15:0] mem4 [0:15];
  int          lat = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [15:0] req_addr = '0;
  logic        req_prev = 1'b0;
  logic        req4_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(
    .ADDR_W       (AW),
    .RESET_VECTOR ('0)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .imm          (imm),
    .inst_pc      (inst_pc)
  );

  fetch_unit #(
    .ADDR_W       (4),
    .RESET_VECTOR (4'hF)
  ) u_dut4 (
    .clk          (clk),
    .rst_n        (rst4_n),
    .imem_req     (req4),
    .imem_addr    (addr4),
    .imem_valid   (valid4),
    .imem_rdata   (rdata4),
    .pc_load      (pc_load4),
    .pc_load_addr (pc_load_addr4),
    .inst_valid   (inst_valid4),
    .inst_ready   (ready4),
    .inst         (inst4),
    .imm          (imm4),
    .inst_pc      (inst_pc4)
  );

  // Zero-wait memory for the narrow instance.
  assign valid4 = req4;
  assign rdata4 = mem4[addr4];

  // Main memory: captures a request, answers after 'lat' further cycles, even if req drops.
  always begin
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (!busy && imem_req) begin
        busy     = 1'b1;
        cnt      = 0;
        req_addr = imem_addr;
      end
      if (busy) begin
        if (cnt >= lat) begin
          imem_valid = 1'b1;
          imem_rdata = mem[req_addr[7:0]];
          busy       = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every new request and every accepted instruction is checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && !req_prev) begin
        tests++;
        if (exp_req.size() == 0) begin
          fails++;
          $display("FAIL req_addr: unexpected request at %h", imem_addr);
        end else begin
          got_a = exp_req.pop_front();
          if (imem_addr !== got_a) begin
            fails++;
            $display("FAIL req_addr: got %h expected %h", imem_addr, got_a);
          end
        end
      end
      if (inst_valid && inst_ready && !pc_load) begin
        tests++;
        n_hs++;
        hs_cyc.push_back(cyc);
        if (exp_inst.size() == 0) begin
          fails++;
          $display("FAIL issue: unexpected inst %h imm %h pc %h", inst, imm, inst_pc);
        end else begin
          got_e = exp_inst.pop_front();
          if (inst !== got_e.inst || imm !== got_e.imm || inst_pc !== got_e.pc) begin
            fails++;
            $display("FAIL issue: got inst %h imm %h pc %h expected inst %h imm %h pc %h",
                     inst, imm, inst_pc, got_e.inst, got_e.imm, got_e.pc);
          end
        end
      end
    end
    req_prev = rst_n ? imem_req : 1'b0;
    if (rst4_n && req4 && !req4_prev) req4_log.push_back(addr4);
    req4_prev = rst4_n ? req4 : 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_until(input int unsigned kind, input logic [15:0] arg, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      case (kind)
        WValid:   hit = inst_valid;
        WReq:     hit = imem_req && (imem_addr == arg);
        WRsp:     hit = imem_valid && (imem_addr == arg);
        WValidPc: hit = inst_valid && (inst_pc == arg);
        WHs:      hit = (n_hs == int'(arg));
        default:  hit = 1'b1;
      endcase
      if (!hit) step();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: timed out, got no event, required event arg %h", name, arg);
    end
  endtask

  task automatic redirect(input logic [15:0] target);
    pc_load      = 1'b1;
    pc_load_addr = target;
    step();
    pc_load      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    rst4_n        = 1'b0;
    pc_load       = 1'b0;
    pc_load_addr  = '0;
    pc_load4      = 1'b0;
    pc_load_addr4 = '0;
    inst_ready    = 1'b1;
    ready4        = 1'b1;
    lat           = 0;
    for (int a = 0; a < 256; a++) mem[a] = 16'hF800;
    for (int a = 0; a < 16; a++) mem4[a] = 16'hF800;
    mem[16'h05] = 16'h3901;
    mem[16'h06] = 16'h1234;
    mem[16'h10] = 16'h3955;
    mem[16'h11] = 16'hBEEF;
    mem[16'h20] = 16'h3900;
    mem[16'h21] = 16'hDEAD;
    mem[16'h30] = 16'h1830;
    mem[16'h31] = 16'h2031;
    mem[16'h50] = 16'h2850;
    mem4[15]    = 16'hA003;
    mem4[0]     = 16'h0007;

    repeat (3) step();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 16'h0000);
    check("rst_imm", imm, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);

    // NOP stream at zero wait: one issue every 3 cycles.
    for (int a = 0; a < 5; a++) exp_req.push_back(16'(a));
    for (int a = 0; a < 4; a++) exp_inst.push_back('{inst: 16'hF800, imm: 16'h0000, pc: 16'(a)});
    rst_n = 1'b1;
    step();
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 16'h0000);
    wait_until(WHs, 16'd4, "nop_stream");
    inst_ready = 1'b0;
    wait_until(WValid, 16'h0, "nop_stall");
    check("stall_pc", inst_pc, 16'h0004);
    if (hs_cyc.size() >= 4) begin
      for (int i = 0; i < 3; i++) check("nop_interval", hs_cyc[i+1] - hs_cyc[i], 3);
    end

    // Two-word LDM, latency 2, held in ISSUE for 4 cycles.
    lat = 2;
    exp_req.push_back(16'h0005);
    exp_req.push_back(16'h0006);
    exp_req.push_back(16'h0007);
    exp_inst.push_back('{inst: 16'h3901, imm: 16'h1234, pc: 16'h0005});
    redirect(16'h0005);
    check("redirect_issue_drop", inst_valid, 1'b0);
    wait_until(WValid, 16'h0, "ldm_valid");
    for (int i = 0; i < 4; i++) begin
      check("hold_inst", inst, 16'h3901);
      check("hold_imm", imm, 16'h1234);
      check("hold_pc", inst_pc, 16'h0005);
      check("hold_no_req", imem_req, 1'b0);
      step();
    end
    check("hold_not_accepted", n_hs, 4);
    check("hold_valid_5th", inst_valid, 1'b1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("ldm_accepted", n_hs, 5);
    check("ldm_valid_drop", inst_valid, 1'b0);
    wait_until(WValid, 16'h0, "nop7_stall");
    check("next_fetch_pc", inst_pc, 16'h0007);

    // Redirect while the immediate response is still 3 cycles away.
    lat = 3;
    exp_req.push_back(16'h0010);
    exp_req.push_back(16'h0011);
    exp_req.push_back(16'h0040);
    exp_req.push_back(16'h0041);
    exp_inst.push_back('{inst: 16'hF800, imm: 16'h0000, pc: 16'h0040});
    redirect(16'h0010);
    inst_ready = 1'b1;
    wait_until(WReq, 16'h0011, "imm_req");
    redirect(16'h0040);
    check("drain_no_req", imem_req, 1'b0);
    check("drain_no_valid", inst_valid, 1'b0);
    wait_until(WHs, 16'd6, "issue_40");
    inst_ready = 1'b0;
    wait_until(WValid, 16'h0, "stall_41");
    check("stall_41_pc", inst_pc, 16'h0041);

    // Redirect coincident with a response, then with a handshake.
    lat = 2;
    exp_req.push_back(16'h0020);
    exp_req.push_back(16'h0030);
    exp_req.push_back(16'h0031);
    exp_req.push_back(16'h0050);
    exp_req.push_back(16'h0051);
    exp_inst.push_back('{inst: 16'h1830, imm: 16'h0000, pc: 16'h0030});
    exp_inst.push_back('{inst: 16'h2850, imm: 16'h0000, pc: 16'h0050});
    redirect(16'h0020);
    wait_until(WRsp, 16'h0020, "rsp_20");
    inst_ready = 1'b1;
    redirect(16'h0030);
    check("rsp_drop_no_valid", inst_valid, 1'b0);
    wait_until(WValidPc, 16'h0031, "valid_31");
    redirect(16'h0050);
    check("hs_redirect_drop", inst_valid, 1'b0);
    wait_until(WHs, 16'd8, "issue_50");
    inst_ready = 1'b0;
    wait_until(WValid, 16'h0, "stall_51");
    check("stall_51_pc", inst_pc, 16'h0051);

    // 4-bit PC: SHL at 0xF takes its immediate from 0, then fetches from 1.
    rst4_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (inst_valid4) seen = 1'b1;
        else step();
      end
      check("wrap_valid_seen", seen, 1'b1);
    end
    check("wrap_inst", inst4, 16'hA003);
    check("wrap_imm", imm4, 16'h0007);
    check("wrap_pc", inst_pc4, 4'hF);
    repeat (6) step();
    check("wrap_req_count_ge3", req4_log.size() >= 3, 1'b1);
    if (req4_log.size() >= 3) begin
      check("wrap_req0", req4_log[0], 4'hF);
      check("wrap_req1", req4_log[1], 4'h0);
      check("wrap_req2", req4_log[2], 4'h1);
    end

    check("exp_inst_empty", exp_inst.size(), 0);
    check("exp_req_empty", exp_req.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
